branch_predictor: RTL

Parametrised dynamic branch predictor for the 5-stage pipelined RISC-V core. It adds a fetch-stage next-PC prediction path to replace the fixed predict-not-taken behaviour, and it resolves predictions in the execute stage. The block holds a 2-bit saturating-counter branch history table (BHT), a tagged branch target buffer (BTB) and saturating performance counters. The core top instantiates it beside the PC mux. The hazard unit flushes on `Mispredict_E` instead of on every taken branch.

---
 rtl/branch_predictor.sv | 123 ++++++++++++
 1 files changed

// File: rtl/branch_predictor.sv
// branch_predictor: 2-bit BHT + tagged BTB next-PC predictor with EX-stage
// resolution and saturating performance counters.
// Optional gshare indexing is enabled by defining BP_GSHARE_EN.
module branch_predictor #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned ENTRIES = 64,
  parameter int unsigned COUNT_W = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [XLEN-1:0]             PC_F,
  output logic                        PredTaken_F,
  output logic [XLEN-1:0]             PredTarget_F,
  output logic [$clog2(ENTRIES)-1:0]  PredIndex_F,
  input  logic                        Update_E,
  input  logic                        IsJump_E,
  input  logic [XLEN-1:0]             PC_E,
  input  logic                        Taken_E,
  input  logic [XLEN-1:0]             Target_E,
  input  logic                        PredTaken_E,
  input  logic [XLEN-1:0]             PredTarget_E,
  input  logic [$clog2(ENTRIES)-1:0]  Index_E,
  output logic                        Mispredict_E,
  output logic [XLEN-1:0]             Redirect_E,
  output logic [COUNT_W-1:0]          BranchCount,
  output logic [COUNT_W-1:0]          MispredictCount
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = XLEN - IDX_W - 2;

  logic [1:0]       ctr_q    [ENTRIES];
  logic             valid_q  [ENTRIES];
  logic             jump_q   [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [XLEN-1:0]  target_q [ENTRIES];

  logic [IDX_W-1:0] idx_f;
  logic [TAG_W-1:0] tag_f;
  logic             hit_f;

`ifdef BP_GSHARE_EN
  logic [IDX_W-1:0] ghr_q;

  // Global history of conditional-branch outcomes, oldest bit shifted out
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ghr_q <= '0;
    end else if (Update_E && !IsJump_E) begin
      ghr_q <= {ghr_q[IDX_W-2:0], Taken_E};
    end
  end

  assign idx_f = PC_F[IDX_W+1:2] ^ ghr_q;
`else
  assign idx_f = PC_F[IDX_W+1:2];
`endif

  assign tag_f = PC_F[XLEN-1:IDX_W+2];

  // Fetch-stage lookup; sees pre-update table contents
  always_comb begin
    hit_f        = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
    PredTaken_F  = hit_f && (jump_q[idx_f] || ctr_q[idx_f][1]);
    PredTarget_F = PredTaken_F ? target_q[idx_f] : PC_F + XLEN'(4);
    PredIndex_F  = idx_f;
  end

  // Execute-stage resolution against the prediction carried from fetch
  always_comb begin
    Mispredict_E = Update_E &&
                   ((Taken_E != PredTaken_E) ||
                    (Taken_E && (Target_E != PredTarget_E)));
    Redirect_E   = Taken_E ? Target_E : PC_E + XLEN'(4);
  end

  // BHT counters and BTB control bits, reset to weakly-not-taken / empty
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        ctr_q[IDX_W'(i)]   <= 2'b01;
        valid_q[IDX_W'(i)] <= 1'b0;
        jump_q[IDX_W'(i)]  <= 1'b0;
      end
    end else if (Update_E) begin
      if (!IsJump_E) begin
        if (Taken_E && (ctr_q[Index_E] != 2'b11)) begin
          ctr_q[Index_E] <= ctr_q[Index_E] + 2'd1;
        end else if (!Taken_E && (ctr_q[Index_E] != 2'b00)) begin
          ctr_q[Index_E] <= ctr_q[Index_E] - 2'd1;
        end
      end
      if (Taken_E) begin
        valid_q[Index_E] <= 1'b1;
        jump_q[Index_E]  <= IsJump_E;
      end
    end
  end

  // BTB payload; qualified by valid so it needs no reset
  always_ff @(posedge clk) begin
    if (Update_E && Taken_E) begin
      tag_q[Index_E]    <= PC_E[XLEN-1:IDX_W+2];
      target_q[Index_E] <= Target_E;
    end
  end

  // Saturating performance counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      BranchCount     <= '0;
      MispredictCount <= '0;
    end else begin
      if (Update_E && (BranchCount != '1)) begin
        BranchCount <= BranchCount + COUNT_W'(1);
      end
      if (Mispredict_E && (MispredictCount != '1)) begin
        MispredictCount <= MispredictCount + COUNT_W'(1);
      end
    end
  end

endmodule
